// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller for the RAT MCU.
// Latches rising edges from NUM_CH sources into a pending register, gates them with a
// per-channel mask and the global enable flag, and offers the lowest-index eligible
// channel to the control unit as INT_REQ/INT_ID (IDLE -> REQ -> SERVICE handshake).
// Build option: define INTR_SYNC_EN to add a 2-flop synchronizer on every IRQ_IN bit.
module intr_ctrl #(
   parameter  int unsigned NUM_CH = 8,
   localparam int unsigned ID_W   = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NUM_CH-1:0] IRQ_IN,
   input  logic              MASK_WE,
   input  logic [NUM_CH-1:0] MASK_IN,
   input  logic              I_SET,
   input  logic              I_CLR,
   input  logic              INT_ACK,
   output logic              I_OUT,
   output logic              INT_REQ,
   output logic [ID_W-1:0]   INT_ID,
   output logic [NUM_CH-1:0] PEND_OUT,
   output logic [NUM_CH-1:0] MASK_OUT
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] irq_s;
   logic [NUM_CH-1:0] irq_prev_q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] ack_clr;
   logic              i_out_q, i_out_d;
   logic              req_q, req_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   winner;
   logic              ack_ok;
   logic              any_elig;

`ifdef INTR_SYNC_EN
   logic [NUM_CH-1:0] sync1_q, sync2_q;

   // Two-flop synchronizer for asynchronous interrupt sources
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IRQ_IN;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = IRQ_IN;
`endif

   assign rise     = irq_s & ~irq_prev_q;
   assign elig     = pend_q & mask_q;
   assign any_elig = |elig;
   // Ack is only honoured while a request is actually outstanding
   assign ack_ok   = (state_q == StReq) && INT_ACK;

   // Lowest-index eligible channel wins
   always_comb begin
      winner = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (elig[i]) winner = ID_W'(i);
      end
   end

   // Pending bit of the serviced channel clears on ack; a simultaneous new edge wins
   always_comb begin
      ack_clr = '0;
      if (ack_ok) ack_clr[id_q] = 1'b1;
      pend_d = (pend_q & ~ack_clr) | rise;
   end

   // Global enable: clear (CLI or accepted ack) dominates set
   always_comb begin
      i_out_d = i_out_q;
      if (I_CLR || ack_ok) begin
         i_out_d = 1'b0;
      end else if (I_SET) begin
         i_out_d = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (i_out_q && any_elig) state_d = StReq;
         end
         StReq: begin
            if (ack_ok) begin
               state_d = StService;
            end else if (I_CLR || !mask_q[id_q]) begin
               state_d = StIdle;
            end
         end
         StService: begin
            // RETIE returns to arbitration; CLI in the same cycle keeps us in service
            if (I_SET && !I_CLR) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs (next values of the registered request and ID)
   always_comb begin
      req_d = (state_d == StReq);
      id_d  = id_q;
      // ID is captured only on grant and held through REQ and SERVICE
      if (state_q == StIdle && state_d == StReq) id_d = winner;
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         irq_prev_q <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         i_out_q    <= 1'b0;
         req_q      <= 1'b0;
         id_q       <= '0;
      end else begin
         irq_prev_q <= irq_s;
         pend_q     <= pend_d;
         if (MASK_WE) mask_q <= MASK_IN;
         i_out_q    <= i_out_d;
         req_q      <= req_d;
         id_q       <= id_d;
      end
   end

   assign I_OUT    = i_out_q;
   assign INT_REQ  = req_q;
   assign INT_ID   = id_q;
   assign PEND_OUT = pend_q;
   assign MASK_OUT = mask_q;

endmodule
